// File: rtl/fetch_ctrl_pkg.sv
// Shared datapath defines: fetch FSM encodings, reset PC and npc op codes.
// fetch_ctrl and the npc block both import this package.
`timescale 1ns/1ps
package fetch_ctrl_pkg;

  // Word address of the first instruction (byte address 0x0000_3000)
  localparam logic [29:0] RESET_PC_DEFAULT = 30'h0000_0C00;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_ISSUE = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  // Next-PC selection codes consumed by the npc block
  localparam logic [1:0] NPC_OP_SEQ    = 2'd0;
  localparam logic [1:0] NPC_OP_BRANCH = 2'd1;
  localparam logic [1:0] NPC_OP_JUMP   = 2'd2;
  localparam logic [1:0] NPC_OP_JREG   = 2'd3;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, holds the fetched
// instruction until decode accepts it, then loads the PC from the external npc block.
`timescale 1ns/1ps
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [29:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:2] pc_out,
  input  logic [31:2] npc_pc,
  output logic        imem_req,
  output logic [31:2] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        halt_req,
  input  logic        resume,
  output logic        halted,
  output logic [31:0] fetch_cnt
);

  logic [2:0]  state_q, state_d;
  logic [29:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: state_d = halt_req ? ST_HALT : ST_FETCH;
      ST_FETCH: begin
        if (imem_gnt) state_d = ST_WAIT;
      end
      // Read data is only meaningful here; a granted request always completes.
      ST_WAIT: begin
        if (imem_rvalid) begin
          inst_d  = imem_rdata;
          valid_d = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (inst_ready) begin
          pc_d    = npc_pc;
          valid_d = 1'b0;
          cnt_d   = cnt_q + 32'd1;
          state_d = halt_req ? ST_HALT : ST_FETCH;
        end
      end
      ST_HALT: begin
        if (resume) state_d = ST_FETCH;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= 32'd0;
      valid_q <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_out     = pc_q;
  assign imem_addr  = pc_q;
  assign imem_req   = (state_q == ST_FETCH);
  assign inst_out   = inst_q;
  assign inst_valid = valid_q;
  assign halted     = (state_q == ST_HALT);
  assign fetch_cnt  = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: memory and decode handshakes driven step by step,
// fetched instructions tracked through a scoreboard queue.
`timescale 1ns/1ps
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:2] pc_out;
  logic [31:2] npc_pc;
  logic        imem_req;
  logic [31:2] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst_out;
  logic        inst_valid;
  logic        inst_ready;
  logic        halt_req;
  logic        resume;
  logic        halted;
  logic [31:0] fetch_cnt;

  fetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .pc_out      (pc_out),
    .npc_pc      (npc_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_out    (inst_out),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .halt_req    (halt_req),
    .resume      (resume),
    .halted      (halted),
    .fetch_cnt   (fetch_cnt)
  );

  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] inst;
  } item_t;

  item_t       sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          t_start;
  logic [29:0] exp_pc;
  logic [31:0] exp_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge with the DUT in FETCH; returns one negedge after acceptance.
  task automatic fetch_one(input int gnt_wait, input int rv_wait, input int rdy_wait,
                           input logic [31:0] data, input logic [29:0] npc, input bit halt_wait);
    item_t it;
    check("fetch_req", 64'(imem_req), 64'd1);
    check("fetch_addr", 64'(imem_addr), 64'(exp_pc));
    for (int i = 0; i < gnt_wait; i++) begin
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_0000 + 32'(i);
      @(negedge clk);
      imem_rvalid = 1'b0;
      check("fetch_hold_req", 64'(imem_req), 64'd1);
      check("rvalid_ignored_fetch", 64'(inst_valid), 64'd0);
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    check("wait_req", 64'(imem_req), 64'd0);
    check("wait_valid", 64'(inst_valid), 64'd0);
    if (halt_wait) halt_req = 1'b1;
    for (int i = 0; i < rv_wait; i++) begin
      @(negedge clk);
      check("wait_hold_valid", 64'(inst_valid), 64'd0);
      check("wait_hold_req", 64'(imem_req), 64'd0);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    it.pc   = exp_pc;
    it.inst = data;
    sb.push_back(it);
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hFFFF_FFFF;
    it = sb.pop_front();
    check("issue_valid", 64'(inst_valid), 64'd1);
    check("issue_inst", 64'(inst_out), 64'(it.inst));
    check("issue_pc", 64'(pc_out), 64'(it.pc));
    for (int i = 0; i < rdy_wait; i++) begin
      inst_ready = 1'b0;
      npc_pc     = 30'h3FFF_FFF0 ^ 30'(i);
      @(negedge clk);
      check("bp_valid", 64'(inst_valid), 64'd1);
      check("bp_inst", 64'(inst_out), 64'(it.inst));
      check("bp_pc", 64'(pc_out), 64'(it.pc));
      check("bp_req", 64'(imem_req), 64'd0);
    end
    npc_pc     = npc;
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    exp_pc  = npc;
    exp_cnt = exp_cnt + 32'd1;
    check("accept_pc", 64'(pc_out), 64'(exp_pc));
    check("accept_cnt", 64'(fetch_cnt), 64'(exp_cnt));
    check("accept_valid", 64'(inst_valid), 64'd0);
    check("accept_halted", 64'(halted), 64'(halt_wait));
    check("accept_req", 64'(imem_req), 64'(!halt_wait));
  endtask

  initial begin
    rst = 1'b1;  npc_pc = '0;  imem_gnt = 1'b0;  imem_rvalid = 1'b0;  imem_rdata = '0;
    inst_ready = 1'b0;  halt_req = 1'b0;  resume = 1'b0;
    exp_pc  = 30'h0C00;
    exp_cnt = 32'd0;

    // Reset held two cycles
    repeat (2) @(negedge clk);
    check("rst_pc", 64'(pc_out), 64'h0C00);
    check("rst_valid", 64'(inst_valid), 64'd0);
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_cnt", 64'(fetch_cnt), 64'd0);
    check("rst_inst", 64'(inst_out), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    rst = 1'b0;
    #1;
    check("idle_req", 64'(imem_req), 64'd0);
    @(negedge clk);

    // First instruction, then a zero-wait stream of ten
    fetch_one(0, 0, 0, 32'h2408_0005, 30'(exp_pc + 30'd1), 1'b0);
    check("first_pc", 64'(pc_out), 64'h0C01);
    t_start = cyc;
    for (int i = 0; i < 10; i++)
      fetch_one(0, 0, 0, 32'h2408_0005 + 32'(i), 30'(exp_pc + 30'd1), 1'b0);
    check("throughput_cycles", 64'(cyc - t_start), 64'd30);

    // Slow grant, slow data, four cycles of backpressure
    fetch_one(1, 2, 4, 32'h8C09_0004, 30'(exp_pc + 30'd1), 1'b0);

    // Branch redirect
    fetch_one(0, 0, 0, 32'h1000_0003, 30'h0C10, 1'b0);
    check("redirect_addr", 64'(imem_addr), 64'h0C10);
    fetch_one(0, 1, 0, 32'h0000_0000, 30'(exp_pc + 30'd1), 1'b0);

    // Halt raised during WAIT: instruction still issues, then HALT
    fetch_one(0, 3, 0, 32'h3C01_1234, 30'h0C20, 1'b1);
    for (int i = 0; i < 2; i++) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBAD0_0000 + 32'(i);
      @(negedge clk);
      imem_rvalid = 1'b0;
      check("halt_halted", 64'(halted), 64'd1);
      check("halt_req", 64'(imem_req), 64'd0);
      check("halt_valid", 64'(inst_valid), 64'd0);
      check("halt_pc", 64'(pc_out), 64'h0C20);
    end
    resume = 1'b1;
    @(negedge clk);
    resume   = 1'b0;
    halt_req = 1'b0;
    check("resume_halted", 64'(halted), 64'd0);
    check("resume_req", 64'(imem_req), 64'd1);
    check("resume_addr", 64'(imem_addr), 64'h0C20);
    fetch_one(0, 0, 0, 32'h2402_000A, 30'(exp_pc + 30'd1), 1'b0);

    // Reset during WAIT, late rvalid lands in IDLE
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst         = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_BAD0;
    #1;
    check("late_idle_req", 64'(imem_req), 64'd0);
    @(negedge clk);
    imem_rvalid = 1'b0;
    exp_pc  = 30'h0C00;
    exp_cnt = 32'd0;
    check("late_valid", 64'(inst_valid), 64'd0);
    check("late_inst", 64'(inst_out), 64'd0);
    check("late_pc", 64'(pc_out), 64'h0C00);
    check("late_cnt", 64'(fetch_cnt), 64'd0);
    fetch_one(0, 0, 0, 32'h2408_0007, 30'(exp_pc + 30'd1), 1'b0);

    // halt_req at reset release goes IDLE -> HALT
    halt_req = 1'b1;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_halt_halted", 64'(halted), 64'd1);
    check("idle_halt_req", 64'(imem_req), 64'd0);
    resume = 1'b1;
    @(negedge clk);
    resume   = 1'b0;
    halt_req = 1'b0;
    check("idle_resume_req", 64'(imem_req), 64'd1);
    check("idle_resume_addr", 64'(imem_addr), 64'h0C00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
